// File: rtl/reg_file_pkg.sv
// Shared constants and types for the reg_file slice.
// Build option: REG_FILE_BYPASS_EN enables write-through forwarding on the read ports.
package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: range/zero-register masking plus optional forwarding.
// Build option: REG_FILE_BYPASS_EN adds the write-through mux from the pending write.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [ADDR_W-1:0] rd_addr,
`ifdef REG_FILE_BYPASS_EN
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    rd_data = '0;
    // Address 0 and unpopulated addresses always read as zero.
    if ((rd_addr != '0) && (32'(rd_addr) < NUM_REGS)) begin
      rd_data = regs[rd_addr];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && !rst && (wr_addr != '0) && (rd_addr == wr_addr)) begin
      rd_data = wr_data;
    end
`endif
  end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with register 0 hardwired to zero.
// Build option: REG_FILE_BYPASS_EN forwards D1 to a read port addressing W1 during a write.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  input  logic [ADDR_W-1:0] W1,
  input  logic [DATA_W-1:0] D1,
  input  logic              WE,
  output logic [DATA_W-1:0] Out1,
  output logic [DATA_W-1:0] Out2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (WE && (W1 != '0) && (32'(W1) < NUM_REGS)) begin
      regs_d[W1] = D1;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd_port1 (
    .regs    (regs_q),
    .rd_addr (R1),
`ifdef REG_FILE_BYPASS_EN
    .rst     (rst),
    .wr_en   (WE),
    .wr_addr (W1),
    .wr_data (D1),
`endif
    .rd_data (Out1)
  );

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd_port2 (
    .regs    (regs_q),
    .rd_addr (R2),
`ifdef REG_FILE_BYPASS_EN
    .rst     (rst),
    .wr_en   (WE),
    .wr_addr (W1),
    .wr_data (D1),
`endif
    .rd_data (Out2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] R1, R2, W1;
  logic [DATA_W-1:0] D1;
  logic              WE;
  logic [DATA_W-1:0] Out1, Out2;

  int n_cmp;
  int n_bad;

  reg_file dut (
    .clk  (clk),
    .rst  (rst),
    .R1   (R1),
    .R2   (R2),
    .W1   (W1),
    .D1   (D1),
    .WE   (WE),
    .Out1 (Out1),
    .Out2 (Out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                           input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    W1 = a; D1 = d; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic read2(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    R1 = a1; R2 = a2;
    #1;
  endtask

  logic [DATA_W-1:0] exp_fwd;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; WE = 1'b0; W1 = '0; D1 = '0; R1 = '0; R2 = '0;

    // Reset with a simultaneous write that must be discarded.
    rst = 1'b1; WE = 1'b1; W1 = 5'd4; D1 = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; WE = 1'b0;
    read2(5'd2, 5'd5);
    check_val("rst_out1_r2", Out1, 32'd0);
    check_val("rst_out2_r5", Out2, 32'd0);
    for (int a = 0; a < 32; a++) begin
      read2(5'(a), 5'(31 - a));
      check_val($sformatf("rst_sweep1_%0d", a), Out1, 32'd0);
      check_val($sformatf("rst_sweep2_%0d", 31 - a), Out2, 32'd0);
    end

    do_write(5'd2, 32'd25);
    read2(5'd2, 5'd1);
    check_val("wr2_out1", Out1, 32'd25);
    check_val("wr2_out2_r1", Out2, 32'd0);

    do_write(5'd5, 32'd3);
    read2(5'd5, 5'd5);
    check_val("wr5_out1", Out1, 32'd3);
    check_val("wr5_out2", Out2, 32'd3);
    do_write(5'd5, 32'd3);
    read2(5'd5, 5'd5);
    check_val("wr5_rep_out1", Out1, 32'd3);
    check_val("wr5_rep_out2", Out2, 32'd3);

    do_write(5'd0, 32'hFFFF_FFFF);
    read2(5'd0, 5'd0);
    check_val("wr0_out1", Out1, 32'd0);
    check_val("wr0_out2", Out2, 32'd0);

    // Write pending to 7: old value unless forwarding is built in.
`ifdef REG_FILE_BYPASS_EN
    exp_fwd = 32'd9;
`else
    exp_fwd = 32'd0;
`endif
    W1 = 5'd7; D1 = 32'd9; WE = 1'b1;
    read2(5'd7, 5'd2);
    check_val("pend7_out1", Out1, exp_fwd);
    check_val("pend7_out2_r2", Out2, 32'd25);
    tick();
    WE = 1'b0;
    read2(5'd7, 5'd7);
    check_val("post7_out1", Out1, 32'd9);
    check_val("post7_out2", Out2, 32'd9);

    // Pending write to address 0 never forwards.
    W1 = 5'd0; D1 = 32'h1234_5678; WE = 1'b1;
    read2(5'd0, 5'd0);
    check_val("pend0_out1", Out1, 32'd0);
    check_val("pend0_out2", Out2, 32'd0);
    WE = 1'b0;

    // WE low: data presented on the write port is not stored.
    W1 = 5'd2; D1 = 32'd77; WE = 1'b0;
    tick();
    read2(5'd2, 5'd7);
    check_val("we0_out1", Out1, 32'd25);
    check_val("we0_out2", Out2, 32'd9);

    do_write(5'd31, 32'hA5A5_5A5A);
    do_write(5'd1, 32'h0000_0001);
    do_write(5'd16, 32'h8000_0000);
    read2(5'd31, 5'd1);
    check_val("wr31_out1", Out1, 32'hA5A5_5A5A);
    check_val("wr1_out2", Out2, 32'h0000_0001);
    read2(5'd16, 5'd31);
    check_val("wr16_out1", Out1, 32'h8000_0000);
    check_val("wr31_out2", Out2, 32'hA5A5_5A5A);

    // Reset overrides a write on the same edge.
    rst = 1'b1; WE = 1'b1; W1 = 5'd3; D1 = 32'd4;
    tick();
    rst = 1'b0; WE = 1'b0;
    read2(5'd2, 5'd3);
    check_val("rstwr_r2", Out1, 32'd0);
    check_val("rstwr_r3", Out2, 32'd0);
    read2(5'd5, 5'd31);
    check_val("rstwr_r5", Out1, 32'd0);
    check_val("rstwr_r31", Out2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
